sb_rx_fpga_batch: RTL



---
 rtl/sb_rx_fpga_batch.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/sb_rx_fpga_batch.sv
// Switchboard SPSC queue consumer: pops packets from host memory into a local output FIFO,
// caching head/tail and writing the tail back to the host once per batch.
module sb_rx_fpga_batch #(
    parameter int unsigned DW            = 256,
    parameter int unsigned MAX_BATCH     = 4,
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter logic [63:0] HEAD_OFFSET   = 64'd0,
    parameter logic [63:0] TAIL_OFFSET   = 64'd64,
    parameter logic [63:0] PACKET_OFFSET = 64'd128,
    parameter logic [63:0] PACKET_SIZE   = 64'd64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [63:0]   cfg_base_addr,
    input  logic [31:0]   cfg_capacity,
    output logic [DW-1:0] data,
    output logic [31:0]   dest,
    output logic          last,
    output logic          valid,
    input  logic          ready,
    output logic          rvalid,
    output logic [63:0]   raddr,
    input  logic          rready,
    input  logic [511:0]  rdata,
    output logic          wvalid,
    output logic [63:0]   waddr,
    output logic [511:0]  wdata,
    output logic [63:0]   wstrb,
    input  logic          wready,
    output logic          status_idle,
    output logic          status_fault,
    output logic [31:0]   status_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(MAX_BATCH + 1);
    localparam int unsigned EW = DW + 33;
    localparam logic [BW-1:0] MaxBatchW = BW'(MAX_BATCH);
    localparam logic [CW-1:0] DepthW    = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        StIdle,
        StRdTail,
        StRdHead,
        StRdPacket,
        StWrTail,
        StFault
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   head_q, head_d;
    logic [31:0]   tail_q, tail_d;
    logic [31:0]   tail_inc;
    logic [31:0]   rd_word;
    logic          tail_valid_q, tail_valid_d;
    logic [BW-1:0] batch_cnt_q, batch_cnt_d, batch_cnt_inc;
    logic [CW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] fifo_cnt, fifo_cnt_after;
    logic          fifo_full, fifo_empty;
    logic          push, pop;
    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [EW-1:0] fifo_head;
    logic [31:0]   status_count_q;
    logic [63:0]   pkt_addr;

    // Only rdata[32:0] and the payload lane are consumed.
    logic unused_rdata;
    if (DW < 448) begin : g_unused_hi
        assign unused_rdata = ^{rdata[63:33], rdata[511:64+DW]};
    end else begin : g_unused_lo
        assign unused_rdata = ^rdata[63:33];
    end

    // Output FIFO bookkeeping; pointers carry one extra wrap bit.
    assign fifo_cnt       = wptr_q - rptr_q;
    assign fifo_full      = (fifo_cnt == DepthW);
    assign fifo_empty     = (fifo_cnt == '0);
    assign fifo_cnt_after = fifo_cnt + CW'(1) - CW'(pop);
    assign fifo_head      = fifo_mem[rptr_q[AW-1:0]];

    assign valid = !fifo_empty;
    assign pop   = valid && ready;
    assign {last, dest, data} = fifo_empty ? '0 : fifo_head;

    assign rd_word       = rdata[31:0];
    assign tail_inc      = (tail_q + 32'd1 == cfg_capacity) ? 32'd0 : tail_q + 32'd1;
    assign batch_cnt_inc = batch_cnt_q + BW'(1);
    assign pkt_addr      = cfg_base_addr + PACKET_OFFSET + {32'd0, tail_q} * PACKET_SIZE;

    assign status_idle  = (state_q == StIdle);
    assign status_fault = (state_q == StFault);
    assign status_count = status_count_q;

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        tail_d       = tail_q;
        tail_valid_d = tail_valid_q;
        batch_cnt_d  = batch_cnt_q;
        push         = 1'b0;
        rvalid       = 1'b0;
        raddr        = '0;
        wvalid       = 1'b0;
        waddr        = '0;
        wdata        = '0;
        wstrb        = '0;

        unique case (state_q)
            StIdle: begin
                if (!en) begin
                    tail_valid_d = 1'b0;
                end else if (cfg_capacity < 32'd2) begin
                    state_d = StFault;
                end else if (!fifo_full) begin
                    if (!tail_valid_q) begin
                        state_d = StRdTail;
                    end else if (head_q == tail_q) begin
                        state_d = StRdHead;
                    end else begin
                        state_d = StRdPacket;
                    end
                end
            end

            StRdTail: begin
                rvalid = 1'b1;
                raddr  = cfg_base_addr + TAIL_OFFSET;
                if (rready) begin
                    tail_d       = rd_word;
                    tail_valid_d = 1'b1;
                    if (rd_word >= cfg_capacity) begin
                        state_d = StFault;
                    end else if (rd_word == head_q) begin
                        state_d = StRdHead;
                    end else begin
                        state_d = StRdPacket;
                    end
                end
            end

            StRdHead: begin
                rvalid = 1'b1;
                raddr  = cfg_base_addr + HEAD_OFFSET;
                if (rready) begin
                    head_d = rd_word;
                    if (rd_word >= cfg_capacity) begin
                        state_d = StFault;
                    end else if (rd_word == tail_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = StRdPacket;
                    end
                end
            end

            StRdPacket: begin
                rvalid = 1'b1;
                raddr  = pkt_addr;
                if (rready) begin
                    push        = 1'b1;
                    tail_d      = tail_inc;
                    batch_cnt_d = batch_cnt_inc;
                    // Keep the batch going only while the next pop is guaranteed a FIFO slot.
                    if (!(en && (batch_cnt_inc < MaxBatchW) && (tail_inc != head_q) &&
                          (fifo_cnt_after < DepthW))) begin
                        state_d = StWrTail;
                    end
                end
            end

            StWrTail: begin
                wvalid = 1'b1;
                waddr  = cfg_base_addr + TAIL_OFFSET;
                wdata  = {480'd0, tail_q};
                wstrb  = 64'hff;
                if (wready) begin
                    batch_cnt_d = '0;
                    state_d     = StIdle;
                end
            end

            StFault: begin
                state_d = StFault;
            end

            default: begin
                state_d = StFault;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            head_q         <= '0;
            tail_q         <= '0;
            tail_valid_q   <= 1'b0;
            batch_cnt_q    <= '0;
            wptr_q         <= '0;
            rptr_q         <= '0;
            status_count_q <= '0;
        end else begin
            state_q      <= state_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            tail_valid_q <= tail_valid_d;
            batch_cnt_q  <= batch_cnt_d;
            if (push) begin
                wptr_q <= wptr_q + CW'(1);
            end
            if (pop) begin
                rptr_q         <= rptr_q + CW'(1);
                status_count_q <= status_count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q[AW-1:0]] <= {rdata[32], rdata[31:0], rdata[64 +: DW]};
        end
    end

    assert property (@(posedge clk) disable iff (reset) !(push && fifo_full));

endmodule
